// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state
// encoding, sequential PC step and the NOP used for empty slots.
package ifu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HOLD   = 2'd2
    } ifu_state_e;

    localparam int          PC_STEP   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/ifu_hold_buffer.sv
// One-entry {instruction, pc} buffer that parks a fetched word while
// decode stalls.
// Ports: clk, reset (async, active-high); write loads wr_instr/wr_pc;
// read consumes the entry; clear empties it; rd_instr/rd_pc present
// the entry (NOP / 0 when empty).
module ifu_hold_buffer
    import ifu_pkg::*;
#(
    parameter int PC_WIDTH = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write,
    input  logic                read,
    input  logic                clear,
    input  logic [31:0]         wr_instr,
    input  logic [PC_WIDTH-1:0] wr_pc,
    output logic [31:0]         rd_instr,
    output logic [PC_WIDTH-1:0] rd_pc
);

    logic                valid;
    logic [31:0]         instr_q;
    logic [PC_WIDTH-1:0] pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (clear) begin
            valid   <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (write) begin
            valid   <= 1'b1;
            instr_q <= wr_instr;
            pc_q    <= wr_pc;
        end else if (read) begin
            valid   <= 1'b0;
        end
    end

    assign rd_instr = valid ? instr_q : NOP_INSTR;
    assign rd_pc    = valid ? pc_q : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives imem requests, feeds IF/ID, handles
// decode stalls (HOLD) and branch redirects (SQUASH).
// Ports: clk, reset (async, active-high), stall, redirect/redirect_pc,
// imem_req/imem_addr/imem_ready/imem_rdata, load_enable,
// instruction_out, pc_out.
// Optional macro IFU_DELAY_SLOT_EN: the word in flight or buffered when
// a redirect arrives is delivered once as a delay slot.
module if_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                  PC_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic                load_enable,
    output logic [31:0]         instruction_out,
    output logic [PC_WIDTH-1:0] pc_out
);

    ifu_state_e          state, state_n;
    logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_n;
    logic [PC_WIDTH-1:0] pending_pc, pending_pc_n;
    logic [PC_WIDTH-1:0] target, seq_pc;
    logic                hs, deliver;
    logic                buf_wr, buf_rd, buf_clr;
    logic [31:0]         deliver_instr, buf_instr;
    logic [PC_WIDTH-1:0] deliver_pc, buf_pc;

    // Reset gates the request so nothing is issued while held.
    assign imem_req  = ~reset & (state != HOLD);
    assign imem_addr = fetch_pc;
    assign hs        = imem_req & imem_ready;
    assign seq_pc    = fetch_pc + PC_WIDTH'(PC_STEP);

    ifu_hold_buffer #(
        .PC_WIDTH (PC_WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .write    (buf_wr),
        .read     (buf_rd),
        .clear    (buf_clr),
        .wr_instr (imem_rdata),
        .wr_pc    (fetch_pc),
        .rd_instr (buf_instr),
        .rd_pc    (buf_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= FETCH;
            fetch_pc        <= PC_RESET;
            pending_pc      <= '0;
            load_enable     <= 1'b0;
            instruction_out <= NOP_INSTR;
            pc_out          <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            pending_pc  <= pending_pc_n;
            load_enable <= deliver;
            if (deliver) begin
                instruction_out <= deliver_instr;
                pc_out          <= deliver_pc;
            end
        end
    end

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        pending_pc_n  = pending_pc;
        target        = pending_pc;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = fetch_pc;
        buf_wr        = 1'b0;
        buf_rd        = 1'b0;
        buf_clr       = 1'b0;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    if (hs) begin
                        fetch_pc_n = redirect_pc;
`ifdef IFU_DELAY_SLOT_EN
                        if (stall) begin
                            buf_wr  = 1'b1;
                            state_n = HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
`endif
                    end else begin
                        pending_pc_n = redirect_pc;
                        state_n      = SQUASH;
                    end
                end else if (hs) begin
                    fetch_pc_n = seq_pc;
                    if (stall) begin
                        buf_wr  = 1'b1;
                        state_n = HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            SQUASH: begin
                // A fresh redirect replaces the pending target.
                target = redirect ? redirect_pc : pending_pc;
                if (hs) begin
                    fetch_pc_n = target;
                    state_n    = FETCH;
`ifdef IFU_DELAY_SLOT_EN
                    if (stall) begin
                        buf_wr  = 1'b1;
                        state_n = HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
`endif
                end else begin
                    pending_pc_n = target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    fetch_pc_n = redirect_pc;
`ifdef IFU_DELAY_SLOT_EN
                    if (!stall) begin
                        deliver       = 1'b1;
                        deliver_instr = buf_instr;
                        deliver_pc    = buf_pc;
                        buf_rd        = 1'b1;
                        state_n       = FETCH;
                    end
`else
                    buf_clr = 1'b1;
                    state_n = FETCH;
`endif
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_instr;
                    deliver_pc    = buf_pc;
                    buf_rd        = 1'b1;
                    state_n       = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 9, the width of every program-counter signal.
REQ-002 The block SHALL have parameter PC_RESET, default 0, the first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port stall  input  1  hazard stall from decode; IF/ID must not load.
REQ-006 The block SHALL have port redirect  input  1  taken branch or jump, one-cycle pulse.
REQ-007 The block SHALL have port redirect_pc  input  PC_WIDTH  target address, valid with redirect.
REQ-008 The block SHALL have port imem_req  output  1  instruction-memory request.
REQ-009 The block SHALL have port imem_addr  output  PC_WIDTH  request address.
REQ-010 The block SHALL have port imem_ready  input  1  memory completes the request this cycle.
REQ-011 The block SHALL have port imem_rdata  input  32  instruction word, valid with imem_ready.
REQ-012 The block SHALL have port load_enable  output  1  IF/ID load strobe.
REQ-013 The block SHALL have port instruction_out  output  32  instruction to IF/ID.
REQ-014 The block SHALL have port pc_out  output  PC_WIDTH  address of instruction_out.

Function
REQ-015 The block SHALL have states FETCH, SQUASH and HOLD; a handshake SHALL be a cycle with imem_req and imem_ready both high.
REQ-016 In FETCH and SQUASH, imem_req SHALL be 1 with imem_addr = fetch_pc; in HOLD, imem_req SHALL be 0.
REQ-017 imem_addr SHALL remain stable from imem_req rising until the handshake, whatever the other inputs do.
REQ-018 In FETCH, a handshake with stall=0 SHALL, on the next edge, set instruction_out=imem_rdata, pc_out=fetch_pc and load_enable=1 (latency 1), and advance fetch_pc by 4.
REQ-019 In FETCH, a handshake with stall=1 SHALL write imem_rdata and fetch_pc into the hold buffer, advance fetch_pc by 4 and enter HOLD.
REQ-020 In HOLD, the cycle stall drops SHALL deliver the buffered pair with load_enable=1 on the next edge and return to FETCH.
REQ-021 load_enable SHALL be a one-cycle pulse per delivered instruction; instruction_out and pc_out SHALL hold their values while load_enable=0.
REQ-022 fetch_pc SHALL increment modulo 2^PC_WIDTH (508+4 wraps to 0 for PC_WIDTH=9).
REQ-023 A redirect in FETCH without a handshake SHALL latch redirect_pc into pending_pc and enter SQUASH.
REQ-024 SQUASH SHALL discard the returning word and, on its handshake, load fetch_pc=pending_pc and return to FETCH.
REQ-025 A redirect coinciding with a FETCH handshake SHALL discard that word and load fetch_pc=redirect_pc, staying in FETCH.
REQ-026 A redirect in HOLD SHALL discard the buffer, load fetch_pc=redirect_pc and enter FETCH.
REQ-027 A redirect in SQUASH SHALL overwrite pending_pc, so the last target wins.
REQ-028 Redirect SHALL take priority over stall in the same cycle.

Reset
REQ-029 Asserting reset SHALL immediately force state=FETCH, fetch_pc=PC_RESET, pending_pc=0, hold buffer clear, load_enable=0, instruction_out=0, pc_out=0 and imem_req=0.
REQ-030 After reset deasserts, imem_req SHALL rise in the first cycle, with imem_addr=PC_RESET.
REQ-031 Reset during an outstanding request SHALL abandon it; no data from it SHALL be delivered.

Configuration
REQ-032 With macro IFU_DELAY_SLOT_EN defined, the word in flight (FETCH/SQUASH) or buffered (HOLD) at the redirect cycle SHALL be delivered once as the delay slot, subject to stall; later sequential words SHALL be discarded.
REQ-033 Without IFU_DELAY_SLOT_EN, every word fetched before the redirect target SHALL be discarded (REQ-023..REQ-027).

Structure
REQ-034 Shared package ifu_pkg SHALL hold the state encoding, PC_STEP=4 and NOP_INSTR=32'h0.
REQ-035 The hold buffer SHALL be sub-module ifu_hold_buffer, a one-entry {instruction, pc} register with write, read and clear inputs.

Verification
REQ-036 Release reset; imem_ready=1 always; rdata=addr -> load_enable high from cycle 2 with pc_out 0,4,8,12 on consecutive cycles.
REQ-037 Handshake at pc 8 with stall=1 for 3 cycles -> imem_req=0 during HOLD; one pulse with pc_out=8 after stall drops; next request at addr 12.
REQ-038 imem_ready held low 4 cycles; redirect to 100 in cycle 2 -> imem_addr stable; word discarded; next request at addr 100.
REQ-039 Redirect to 200 coincident with handshake at pc 40 -> no delivery of pc 40 (macro undefined); delivered once with macro defined; next addr 200.
REQ-040 fetch_pc=508 -> next request addr 0; reset mid-request -> imem_req 0, then addr PC_RESET with no stale load_enable.
